// File: rtl/pmic_sampler.sv
// pmic_sampler: periodic sampler for a 16-bit serial ADC that strobes each sample into a FIFO.
// Optional build macro PMIC_SAMPLER_ZERO_CHECK_EN flags any nonzero discarded leading bit via o_err.
module pmic_sampler #(
  parameter int CKDIV = 3,
  parameter int BW    = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [19:0]   i_rate,
  input  logic          i_miso,
  output logic          o_csn,
  output logic          o_sck,
  output logic          o_stb,
  output logic [BW-1:0] o_data,
  output logic          o_err
);

`ifdef PMIC_SAMPLER_ZERO_CHECK_EN
  localparam int SW = 16;
  localparam logic [15:0] LEAD_MASK = 16'(~((32'd1 << BW) - 32'd1));
`else
  // The leading 16-BW bits are never observed, so only BW bits are kept.
  localparam int SW = BW;
`endif

  localparam logic [8:0] HALF_LAST = 9'(CKDIV - 1);
  localparam logic [8:0] STOP_LAST = 9'(2 * CKDIV - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t        state;
  logic [19:0]   cnt;
  logic          tick;
  logic [8:0]    div;
  logic [3:0]    bitc;
  logic [SW-1:0] shift;

  assign tick = i_en && (i_rate != '0) && (cnt == '0);

  // Rate counter: holds at i_rate-1 while disabled, reloads on every tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= i_rate - 20'd1;
    end else if (!i_en || (i_rate == '0) || (cnt == '0)) begin
      cnt <= i_rate - 20'd1;
    end else begin
      cnt <= cnt - 20'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      div    <= '0;
      bitc   <= '0;
      shift  <= '0;
      o_csn  <= 1'b1;
      o_sck  <= 1'b1;
      o_stb  <= 1'b0;
      o_data <= '0;
      o_err  <= 1'b0;
    end else begin
      o_stb <= 1'b0;
      if (tick && (state != IDLE)) begin
        o_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (tick) begin
            state <= START;
            o_csn <= 1'b0;
            o_sck <= 1'b1;
            div   <= '0;
          end
        end
        START: begin
          if (div == HALF_LAST) begin
            state <= SHIFT;
            o_sck <= 1'b0;
            div   <= '0;
            bitc  <= '0;
          end else begin
            div <= div + 9'd1;
          end
        end
        SHIFT: begin
          if (div == HALF_LAST) begin
            div <= '0;
            if (!o_sck) begin
              o_sck <= 1'b1;
              shift <= {shift[SW-2:0], i_miso};
            end else if (bitc == 4'd15) begin
              state  <= STOP;
              o_csn  <= 1'b1;
              o_stb  <= 1'b1;
              o_data <= shift[BW-1:0];
`ifdef PMIC_SAMPLER_ZERO_CHECK_EN
              if ((shift & LEAD_MASK) != '0) begin
                o_err <= 1'b1;
              end
`endif
            end else begin
              bitc  <= bitc + 4'd1;
              o_sck <= 1'b0;
            end
          end else begin
            div <= div + 9'd1;
          end
        end
        STOP: begin
          if (div == STOP_LAST) begin
            state <= IDLE;
            div   <= '0;
          end else begin
            div <= div + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmic_sampler.sv
// Bench for pmic_sampler: event-time frame model plus an ADC model, compared every cycle.
module tb_pmic_sampler;
  localparam int K     = 3;
  localparam int BW    = 12;
  localparam int FRAME = 35 * K;
`ifdef PMIC_SAMPLER_ZERO_CHECK_EN
  localparam logic ZC = 1'b1;
`else
  localparam logic ZC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          miso = 1'b0;
  logic [19:0]   rate = 20'd200;
  logic          csn, sck, stb, err;
  logic [BW-1:0] data;

  pmic_sampler #(.CKDIV(K), .BW(BW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rate(rate), .i_miso(miso),
    .o_csn(csn), .o_sck(sck), .o_stb(stb), .o_data(data), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  logic [15:0] words [8];

  // Reference model: ticks as absolute edge times, outputs as functions of frame position.
  longint        k = 0, next_tick = 0, k0 = 0;
  bit            started = 0, valid = 0;
  int            mframes = 0;
  logic [15:0]   mword = '0;
  logic          exp_csn = 1'b1, exp_sck = 1'b1, exp_stb = 1'b0, exp_err = 1'b0;
  logic [BW-1:0] exp_data = '0;

  function automatic longint period(input logic [19:0] r);
    return (r == 20'd0) ? 64'd1048576 : longint'(r);
  endfunction

  always @(posedge clk) begin
    longint pos;
    bit     tk, busy;
    k++;
    if (rst) begin
      valid     = 1;
      started   = 0;
      exp_err   = 1'b0;
      exp_data  = '0;
      next_tick = k + period(rate);
    end else begin
      tk = en && (rate != 20'd0) && (k == next_tick);
      if (!en || (rate == 20'd0) || tk) next_tick = k + period(rate);
      busy = started && ((k - 1 - k0) < FRAME);
      if (tk) begin
        if (busy) exp_err = 1'b1;
        else begin
          started = 1;
          k0      = k;
          mword   = words[mframes % 8];
          mframes++;
        end
      end
    end
    pos     = k - k0;
    exp_csn = 1'b1;
    exp_sck = 1'b1;
    exp_stb = 1'b0;
    if (started && (pos < FRAME)) begin
      if (pos < 33 * K) exp_csn = 1'b0;
      if ((pos >= K) && (pos < 33 * K) && (((pos - K) % (2 * K)) < K)) exp_sck = 1'b0;
      if (pos == 33 * K) begin
        exp_stb  = 1'b1;
        exp_data = mword[BW-1:0];
        if (ZC && ((mword >> BW) != 16'd0)) exp_err = 1'b1;
      end
    end
  end

  // ADC: presents the next word bit after each falling SCLK edge while selected.
  logic [15:0] aword = '0;
  int          aframes = 0, aidx = 0;
  logic        a_csn = 1'b1, a_sck = 1'b1;
  always @(negedge clk) begin
    if (a_csn && !csn) begin
      aword = words[aframes % 8];
      aframes++;
      aidx = 0;
    end
    if (a_sck && !sck && !csn && (aidx < 16)) begin
      miso = aword[15 - aidx];
      aidx++;
    end
    a_csn = csn;
    a_sck = sck;
  end

  // Compare against the model and collect frame statistics.
  int   cyc = 0, stb_count = 0, csn_falls = 0, last_stb = -1, last_gap = 0;
  int   low_run = 0, last_low = 0, sck_falls = 0, last_sck_falls = 0;
  logic prev_csn = 1'b1, prev_sck = 1'b1, prev_stb = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      check("csn", 32'(csn), 32'(exp_csn));
      check("sck", 32'(sck), 32'(exp_sck));
      check("stb", 32'(stb), 32'(exp_stb));
      check("data", 32'(data), 32'(exp_data));
      check("err", 32'(err), 32'(exp_err));
      if (stb) check("stb_back_to_back", 32'(prev_stb), 32'd0);
    end
    if (stb) begin
      if (last_stb >= 0) last_gap = cyc - last_stb;
      last_stb = cyc;
      stb_count++;
    end
    if (prev_csn && !csn) begin
      csn_falls++;
      low_run   = 0;
      sck_falls = 0;
    end
    if (!csn) begin
      low_run++;
      if (prev_sck && !sck) sck_falls++;
    end
    if (!prev_csn && csn) begin
      last_low       = low_run;
      last_sck_falls = sck_falls;
    end
    prev_csn = csn;
    prev_sck = sck;
    prev_stb = stb;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_words(input logic [15:0] w);
    for (int i = 0; i < 8; i++) words[i] = w;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
  endtask

  task automatic wait_csn_fall(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; (i < 1000) && !ok; i++) begin
      step(1);
      if (!csn) ok = 1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    int c0, s0, f0;

    set_words(16'h0ABC);
    rst = 1'b1; en = 1'b0; rate = 20'd200;
    step(3);
    check("reset_csn", 32'(csn), 32'd1);
    check("reset_sck", 32'(sck), 32'd1);
    check("reset_stb", 32'(stb), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    rst = 1'b0; en = 1'b1;
    step(750);
    check("nominal_gap", 32'(last_gap), 32'd200);
    check("nominal_data", 32'(data), 32'hABC);
    check("nominal_sck_falls", 32'(last_sck_falls), 32'd16);
    check("nominal_csn_low", 32'(last_low), 32'd99);
    check("nominal_err", 32'(err), 32'd0);

    set_words(16'h8ABC);
    step(250);
    check("lead_data", 32'(data), 32'hABC);
    check("lead_err", 32'(err), 32'(ZC));

    rst = 1'b1; en = 1'b0;
    step(1);
    rst = 1'b0; rand_words(); rate = 20'd50; en = 1'b1;
    step(500);
    check("overrun_err", 32'(err), 32'd1);
    check("overrun_gap", 32'(last_gap), 32'd150);

    rst = 1'b1; en = 1'b0; rate = 20'd200;
    step(1);
    rst = 1'b0; en = 1'b1;
    wait_csn_fall("abort_frame_start");
    step(40);
    s0 = stb_count;
    rst = 1'b1;
    step(1);
    check("abort_csn", 32'(csn), 32'd1);
    check("abort_sck", 32'(sck), 32'd1);
    check("abort_stb", 32'(stb), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    rst = 1'b0; en = 1'b0;
    step(150);
    check("abort_no_strobe", 32'(stb_count), 32'(s0));

    rst = 1'b1;
    step(1);
    rst = 1'b0; en = 1'b1;
    wait_csn_fall("endrop_frame_start");
    c0 = cyc;
    step(10);
    en = 1'b0;
    ok = 0;
    for (int i = 0; (i < 200) && !ok; i++) begin
      step(1);
      if (stb) ok = 1;
    end
    check("endrop_strobe_seen", 32'(ok), 32'd1);
    check("endrop_strobe_pos", 32'(cyc - c0), 32'd99);
    f0 = csn_falls;
    step(500);
    check("endrop_no_new_frame", 32'(csn_falls), 32'(f0));

    rand_words();
    rst = 1'b1;
    step(1);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) rate = 20'($urandom_range(30, 400));
      if ($urandom_range(0, 199) == 0) words[$urandom_range(0, 7)] = 16'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      step(1);
    end

    rst = 1'b0; en = 1'b0;
    step(150);
    rate = 20'd0; en = 1'b1;
    f0 = csn_falls;
    s0 = stb_count;
    step(1000);
    check("rate0_no_frame", 32'(csn_falls), 32'(f0));
    check("rate0_no_strobe", 32'(stb_count), 32'(s0));
    check("rate0_csn", 32'(csn), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
